// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - oversampling UART frame receiver feeding the LDPC stage through a small FIFO
module uart_frame_rx #(
  parameter int CLK_DIV    = 651,
  parameter int OVS        = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OVS_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [OVS_W-1:0] OVS_HALF  = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] OVS_LAST  = OVS_W'(OVS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  // Input synchroniser and tick generator state
  logic               r_rx_meta;
  logic               r_rx_s;
  logic [DIV_W-1:0]   r_div_cnt;
  logic               w_tick;

  // Frame FSM state
  state_t             r_state;
  logic [OVS_W-1:0]   r_ovs_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic               r_frame_err;
  logic               r_busy;

  // Output FIFO state
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overrun;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_write;
  logic               w_valid;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Free-running oversample divider; the last count is the tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign w_tick = (r_div_cnt == DIV_LAST);

  // A complete frame with a good stop bit is offered to the FIFO on the stop-centre tick
  assign w_push = (r_state == S_STOP) && w_tick && (r_ovs_cnt == OVS_LAST) && r_rx_s;

  // Frame FSM: start validation at half-bit, data and stop sampled at bit centres
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ovs_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            if (!r_rx_s) begin
              r_state   <= S_START;
              r_ovs_cnt <= '0;
              r_busy    <= 1'b1;
            end
          end
          S_START: begin
            if (r_ovs_cnt == OVS_HALF) begin
              if (r_rx_s) begin
                // Line went back high before mid start bit: treat as noise
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state   <= S_DATA;
                r_ovs_cnt <= '0;
                r_bit_cnt <= '0;
              end
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (r_ovs_cnt == OVS_LAST) begin
              r_ovs_cnt <= '0;
              if (LSB_FIRST != 0) begin
                r_shift <= {r_rx_s, r_shift[DATA_W-1:1]};
              end else begin
                r_shift <= {r_shift[DATA_W-2:0], r_rx_s};
              end
              if (r_bit_cnt == BIT_LAST) begin
                r_state   <= S_STOP;
                r_bit_cnt <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (r_ovs_cnt == OVS_LAST) begin
              r_ovs_cnt <= '0;
              if (r_rx_s) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                // Bad stop bit: flag it and wait for the line to recover before re-arming
                r_state     <= S_WAIT_HI;
                r_frame_err <= 1'b1;
              end
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 1'b1;
            end
          end
          S_WAIT_HI: begin
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = w_valid && out_ready;
  // A full FIFO still takes the frame when the head leaves in the same clock
  assign w_write = w_push && (!w_full || w_pop);

  // Circular FIFO; pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && !w_write;
      if (w_write) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid  = w_valid;
  assign out_data   = w_valid ? r_mem[r_rd_ptr] : '0;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule
